// File: rtl/x86_pkg.sv
// Shared constants for the x86 core front end.
//   BUS_WIDTH         : code bus data width in bits
//   BYTE_LANES        : bytes per bus word
//   DEFAULT_RESET_EIP : instruction pointer after reset
package x86_pkg;
    localparam int          BUS_WIDTH         = 32;
    localparam int          BYTE_LANES        = 4;
    localparam logic [31:0] DEFAULT_RESET_EIP = 32'h0000_0000;
endpackage

// File: rtl/x86_pq_window.sv
// Byte rotator for the prefetch queue: presents WINDOW_BYTES bytes of the
// circular buffer starting at byte index rd_ptr, wrapping around the end.
//   words  : flattened buffer, word w in bits [w*32 +: 32], little-endian
//   rd_ptr : byte index of window byte 0
//   window : byte i in bits [i*8 +: 8]
module x86_pq_window
    import x86_pkg::*;
#(
    parameter int  DEPTH_WORDS  = 4,
    parameter int  WINDOW_BYTES = 8,
    localparam int BYTES        = DEPTH_WORDS * BYTE_LANES,
    localparam int PW           = $clog2(BYTES)
) (
    input  logic [DEPTH_WORDS*BUS_WIDTH-1:0] words,
    input  logic [PW-1:0]                    rd_ptr,
    output logic [WINDOW_BYTES*8-1:0]        window
);

    logic [7:0] byte_lane [BYTES];

    for (genvar b = 0; b < BYTES; b++) begin : g_lane
        assign byte_lane[b] = words[b*8 +: 8];
    end

    // Buffer size is a power of two, so the PW-bit sum wraps naturally.
    always_comb begin
        window = '0;
        for (int i = 0; i < WINDOW_BYTES; i++) begin
            window[i*8 +: 8] = byte_lane[rd_ptr + PW'(i)];
        end
    end

endmodule

// File: rtl/x86_prefetch_queue.sv
// Instruction prefetch queue. Fetches aligned dwords from the code bus into a
// circular buffer and presents the decoder with a byte window at EIP.
//   clock, reset_n          : clock, asynchronous active-low reset
//   o_address, o_rd         : fetch request (dword-aligned address)
//   i_ack, i_data           : memory accept strobe and same-cycle data
//   flush, flush_eip        : restart fetching at any byte address
//   o_window, o_avail       : decoder window and count of valid bytes in it
//   consume, consume_bytes  : retire bytes from the front of the window
//   o_eip                   : address of window byte 0
//
// Handshake: a word transfers on any rising edge where o_rd and i_ack are both
// high; i_data is taken in that same cycle. o_rd depends on registers only, so
// memory may look at it without a combinational loop back through i_ack.
module x86_prefetch_queue
    import x86_pkg::*;
#(
    parameter int          DEPTH_WORDS  = 4,
    parameter int          WINDOW_BYTES = 8,
    parameter logic [31:0] RESET_EIP    = DEFAULT_RESET_EIP,
    localparam int         AW           = $clog2(WINDOW_BYTES + 1)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    output logic [31:0]               o_address,
    output logic                      o_rd,
    input  logic                      i_ack,
    input  logic [31:0]               i_data,
    input  logic                      flush,
    input  logic [31:0]               flush_eip,
    output logic [WINDOW_BYTES*8-1:0] o_window,
    output logic [AW-1:0]             o_avail,
    input  logic                      consume,
    input  logic [AW-1:0]             consume_bytes,
    output logic [31:0]               o_eip
);

    localparam int BYTES = DEPTH_WORDS * BYTE_LANES;
    localparam int PW    = $clog2(BYTES);
    localparam int WW    = $clog2(DEPTH_WORDS);
    localparam int LW    = $clog2(BYTES + 1);
    localparam int OW    = LW + 1;

    logic [PW-1:0]       rd_ptr;
    logic [WW-1:0]       wr_ptr;
    logic [LW-1:0]       level;
    logic [1:0]          skip;
    logic                run;
    logic [29:0]         fetch_word;
    logic [31:0]         eip;
    logic [BUS_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [DEPTH_WORDS*BUS_WIDTH-1:0] words;
    logic [OW-1:0]       occupied;
    logic                transfer;
    logic [AW-1:0]       consume_eff;
    logic [LW-1:0]       added;
    logic [LW-1:0]       level_next;

    for (genvar w = 0; w < DEPTH_WORDS; w++) begin : g_flat
        assign words[w*BUS_WIDTH +: BUS_WIDTH] = mem[w];
    end

    // Words holding unread bytes, counting the partially consumed first word.
    // After an unaligned flush this is already 1: the pending word is reserved.
    assign occupied = (OW'(rd_ptr[1:0]) + OW'(level) + OW'(3)) >> 2;

    assign o_rd      = run & (occupied < OW'(DEPTH_WORDS));
    assign transfer  = o_rd & i_ack;
    assign o_address = {fetch_word, 2'b00};
    assign o_eip     = eip;
    assign o_avail   = (level > LW'(WINDOW_BYTES)) ? AW'(WINDOW_BYTES) : AW'(level);

    // Oversize consumes are clamped to what the window holds.
    assign consume_eff = !consume ? '0 :
                         (consume_bytes > o_avail) ? o_avail : consume_bytes;
    assign added       = transfer ? LW'(3'd4 - {1'b0, skip}) : '0;
    assign level_next  = level + added - LW'(consume_eff);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run        <= 1'b0;
            rd_ptr     <= PW'(RESET_EIP[1:0]);
            wr_ptr     <= '0;
            level      <= '0;
            skip       <= RESET_EIP[1:0];
            fetch_word <= RESET_EIP[31:2];
            eip        <= RESET_EIP;
            for (int w = 0; w < DEPTH_WORDS; w++) begin
                mem[w] <= '0;
            end
        end else begin
            run <= 1'b1;
            if (flush) begin
                // Any word acked this cycle belongs to the old stream: dropped.
                fetch_word <= flush_eip[31:2];
                eip        <= flush_eip;
                rd_ptr     <= PW'(flush_eip[1:0]);
                wr_ptr     <= '0;
                level      <= '0;
                skip       <= flush_eip[1:0];
            end else begin
                if (transfer) begin
                    mem[wr_ptr] <= i_data;
                    wr_ptr      <= wr_ptr + WW'(1);
                    fetch_word  <= fetch_word + 30'd1;
                    skip        <= 2'b00;
                end
                rd_ptr <= rd_ptr + PW'(consume_eff);
                eip    <= eip + 32'(consume_eff);
                level  <= level_next;
            end
        end
    end

    x86_pq_window #(
        .DEPTH_WORDS  (DEPTH_WORDS),
        .WINDOW_BYTES (WINDOW_BYTES)
    ) u_window (
        .words  (words),
        .rd_ptr (rd_ptr),
        .window (o_window)
    );

endmodule

// File: tb/tb_x86_prefetch_queue.sv
module tb_x86_prefetch_queue;

    localparam int DEPTH = 4;
    localparam int W     = 8;
    localparam int AW    = $clog2(W + 1);

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [31:0]   o_address;
    logic          o_rd;
    logic          i_ack = 1'b0;
    logic [31:0]   i_data = '0;
    logic          flush = 1'b0;
    logic [31:0]   flush_eip = '0;
    logic [W*8-1:0] o_window;
    logic [AW-1:0] o_avail;
    logic          consume = 1'b0;
    logic [AW-1:0] consume_bytes = '0;
    logic [31:0]   o_eip;

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    x86_prefetch_queue #(
        .DEPTH_WORDS  (DEPTH),
        .WINDOW_BYTES (W),
        .RESET_EIP    (32'h0000_0000)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .o_address     (o_address),
        .o_rd          (o_rd),
        .i_ack         (i_ack),
        .i_data        (i_data),
        .flush         (flush),
        .flush_eip     (flush_eip),
        .o_window      (o_window),
        .o_avail       (o_avail),
        .consume       (consume),
        .consume_bytes (consume_bytes),
        .o_eip         (o_eip)
    );

    // ---------------- reference model: byte stream from EIP ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    bit          m_run;
    logic [31:0] m_eip;
    logic [31:0] m_fetch;
    logic [1:0]  m_skip;
    logic [31:0] salt;
    int          streamed;

    // Memory image: each byte holds its own low address bits, xor a salt.
    function automatic logic [31:0] data_of(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {b + 8'd3, b + 8'd2, b + 8'd1, b} ^ salt;
    endfunction

    function automatic int exp_avail();
        return (exp_q.size() < W) ? exp_q.size() : W;
    endfunction

    function automatic bit exp_rd();
        int occ;
        occ = (int'(m_eip[1:0]) + exp_q.size() + 3) / 4;
        return m_run && (occ < DEPTH);
    endfunction

    task automatic model_reset();
        m_run   = 1'b0;
        exp_q.delete();
        m_eip   = 32'h0000_0000;
        m_fetch = 32'h0000_0000;
        m_skip  = 2'b00;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [63:0] ew;
        logic [63:0] mask;
        int av;
        av   = exp_avail();
        ew   = '0;
        mask = '0;
        for (int i = 0; i < av; i++) begin
            ew[i*8 +: 8]   = exp_q[i];
            mask[i*8 +: 8] = 8'hFF;
        end
        check("o_rd", 64'(o_rd), 64'(exp_rd()));
        check("o_address", 64'(o_address), 64'(m_fetch));
        check("o_eip", 64'(o_eip), 64'(m_eip));
        check("o_avail", 64'(o_avail), 64'(av));
        if (av > 0) check("o_window", 64'(o_window) & mask, ew);
    endtask

    // ---------------- driver: one cycle, called at a falling edge ----------------
    task automatic step(input bit f, input logic [31:0] fe, input bit a, input bit c, input int cb);
        bit xfer;
        int eff;
        logic [31:0] d;
        flush         = f;
        flush_eip     = fe;
        i_ack         = a;
        i_data        = data_of(m_fetch);
        consume       = c;
        consume_bytes = AW'(cb);
        xfer = exp_rd() && a;
        if (f) begin
            exp_q.delete();
            m_eip   = fe;
            m_fetch = {fe[31:2], 2'b00};
            m_skip  = fe[1:0];
        end else begin
            eff = 0;
            if (c) eff = (cb < exp_avail()) ? cb : exp_avail();
            for (int i = 0; i < eff; i++) void'(exp_q.pop_front());
            m_eip    = m_eip + 32'(eff);
            streamed = streamed + eff;
            if (xfer) begin
                d = data_of(m_fetch);
                for (int k = int'(m_skip); k < 4; k++) exp_q.push_back(d[k*8 +: 8]);
                m_fetch = m_fetch + 32'd4;
                m_skip  = 2'b00;
            end
        end
        m_run = 1'b1;
        @(negedge clock);
        check_outputs();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        int cycles;
        salt = '0;
        streamed = 0;
        model_reset();

        // Reset values
        repeat (2) @(negedge clock);
        check_outputs();
        check("reset_window", 64'(o_window), 64'h0);
        reset_n = 1'b1;

        // Fill from address 0, no consumption
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, 0);
        check("fill_window", 64'(o_window), 64'h0706050403020100);
        check("fill_avail", 64'(o_avail), 64'd8);
        check("fill_rd_low", 64'(o_rd), 64'd0);

        // Free a word, then flush + ack + consume together
        step(1'b0, '0, 1'b0, 1'b1, 4);
        salt = 32'hA5C3_9E17;
        step(1'b1, 32'h0000_1003, 1'b1, 1'b1, 3);
        check("flush_addr", 64'(o_address), 64'h1000);
        check("flush_avail", 64'(o_avail), 64'd0);
        check("flush_eip", 64'(o_eip), 64'h1003);
        step(1'b0, '0, 1'b1, 1'b0, 0);
        d = data_of(32'h0000_1000);
        check("flush_first_avail", 64'(o_avail), 64'd1);
        check("flush_byte0", 64'(o_window[7:0]), 64'(d[31:24]));

        // Full queue streaming 3 bytes per cycle
        salt = $urandom();
        repeat (6) step(1'b0, '0, 1'b1, 1'b0, 0);
        streamed = 0;
        cycles = 0;
        while (streamed < 1000 && cycles < 1500) begin
            step(1'b0, '0, 1'b1, 1'b1, 3);
            cycles++;
        end
        check("stream_total", 64'(streamed >= 1000), 64'd1);

        // Fetch across the top of the address space
        salt = '0;
        step(1'b1, 32'hFFFF_FFFA, 1'b0, 1'b0, 0);
        step(1'b0, '0, 1'b1, 1'b0, 0);
        step(1'b0, '0, 1'b1, 1'b0, 0);
        check("wrap_addr", 64'(o_address), 64'h0);
        step(1'b0, '0, 1'b1, 1'b0, 0);
        check("wrap_window", 64'(o_window), 64'h0100FFFEFDFCFBFA);

        // Oversize consume is clamped; consume on empty is a no-op
        step(1'b1, 32'h0000_2002, 1'b0, 1'b0, 0);
        step(1'b0, '0, 1'b1, 1'b0, 0);
        check("clamp_avail_before", 64'(o_avail), 64'd2);
        step(1'b0, '0, 1'b0, 1'b1, 7);
        check("clamp_avail_after", 64'(o_avail), 64'd0);
        check("clamp_eip", 64'(o_eip), 64'h2004);
        step(1'b0, '0, 1'b0, 1'b1, 5);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            bit f;
            logic [31:0] fe;
            if ($urandom_range(0, 63) == 0) salt = $urandom();
            f  = ($urandom_range(0, 15) == 0);
            fe = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom();
            step(f, fe, ($urandom_range(0, 3) != 0), 1'(($urandom_range(0, 1))), $urandom_range(0, 15));
        end

        // Reset asserted in the middle of an acked request
        flush   = 1'b0;
        consume = 1'b0;
        i_ack   = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("midreset_window", 64'(o_window), 64'h0);
        @(negedge clock);
        @(negedge clock);
        check_outputs();
        reset_n = 1'b1;
        salt = '0;
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 0);
        check("rerun_window", 64'(o_window), 64'h0706050403020100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/x86_prefetch_queue.md
# x86_prefetch_queue

Parametrised instruction prefetch queue for the x86 core. It fetches aligned dwords from the 32-bit code bus into a circular buffer of `DEPTH_WORDS` words. It presents the decoder with a byte-aligned window of `WINDOW_BYTES` bytes starting at the current EIP and retires a variable number of consumed bytes per cycle. A flush restarts fetching at any byte address, including unaligned ones, for jumps. It sits between the memory arbiter and the instruction decoder/executor.

## Interface
- `DEPTH_WORDS`, 4: buffer depth in dwords; power of 2, ≥2.
- `WINDOW_BYTES`, 8: decoder window width in bytes; ≤ `(DEPTH_WORDS-1)*4`.
- `RESET_EIP`, 32'h00000000: fetch start address after reset.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clock`  in  1  clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `o_address`  out  32  dword-aligned fetch address; bits [1:0] are always 0.
- `o_rd`  out  1  fetch request.
- `i_ack`  in  1  memory accepts the request; `i_data` is valid in the same cycle.
- `i_data`  in  32  fetched dword, little-endian.
- `flush`  in  1  restart the queue at `flush_eip`.
- `flush_eip`  in  32  new EIP, any byte alignment.
- `o_window`  out  `WINDOW_BYTES*8`  bytes from EIP onward; byte 0 is in [7:0].
- `o_avail`  out  `$clog2(WINDOW_BYTES+1)`  number of valid window bytes, `min(level, WINDOW_BYTES)`.
- `consume`  in  1  retire bytes this cycle.
- `consume_bytes`  in  `$clog2(WINDOW_BYTES+1)`  number of bytes retired.
- `o_eip`  out  32  address of window byte 0.

## Operation
- State registers:
  - `rd_ptr`: byte index, modulo `DEPTH_WORDS*4`.
  - `wr_ptr`: word index, modulo `DEPTH_WORDS`.
  - `level`: number of valid bytes from `rd_ptr`.
  - `skip`: number of leading bytes of the first word to discard.
  - `run`: fetch-enable flag.
  - `fetch_addr`: next dword to fetch.
  - `eip`.
- Occupied words = `ceil((rd_ptr[1:0] + level)/4)`. `o_rd = run & (occupied < DEPTH_WORDS)`.
- Transfer occurs when `o_rd & i_ack`:
  - Store the word at `wr_ptr`, then increment `wr_ptr`.
  - `fetch_addr += 4`; wraps from 0xFFFFFFFC to 0.
  - `level += 4 - skip`, then `skip = 0`.
- Consume occurs when `consume`:
  - Effective count = `min(consume_bytes, o_avail)`; oversize requests are clamped, never underflow.
  - `rd_ptr`, `eip` and `level` advance by the effective count.
- Transfer and consume in the same cycle: `level_next = level + added - consumed`.
- Flush has priority over transfer and consume in the same cycle; any acked data that cycle is discarded. Flush sets:
  - `fetch_addr = {flush_eip[31:2],2'b00}`
  - `eip = flush_eip`
  - `rd_ptr = flush_eip[1:0]`
  - `wr_ptr = 0`
  - `level = 0`
  - `skip = flush_eip[1:0]`
- Window byte `i` = `buf[(rd_ptr+i) mod DEPTH_WORDS*4]`. Bytes at `i ≥ o_avail` are don't-care.

## Timing
- Reset values:
  - `o_address = RESET_EIP & ~3`, `o_eip = RESET_EIP`.
  - `o_rd = 0`, `o_avail = 0`, `o_window = 0`.
  - `run = 0`, `level = 0`, `skip = RESET_EIP[1:0]`.
- `run` sets on the first rising edge after `reset_n` deasserts, so `o_rd` first rises in the second cycle after deassertion.
- `o_address` is a register. `o_rd`, `o_avail` and `o_window` are combinational from registers only; there is no input-to-output combinational path.
- Latency:
  - Flush at edge T → new `o_address` visible after T.
  - Ack in cycle T+1 → bytes visible in `o_avail`/`o_window` after edge T+1.
- Sustains one dword per cycle with a continuously acked bus.
- Full: `o_rd` drops in the same cycle `occupied` reaches `DEPTH_WORDS`, and reasserts the cycle after a consume frees a word.
- Empty: `o_avail = 0`; a consume is a no-op.
- `reset_n` asserted mid-request: all state returns to reset values immediately; a pending ack is ignored.

## Structure
- Shared package `x86_pkg`: bus width constant (32), byte-lane constant (4), and `RESET_EIP` default.
- One sub-module `x86_pq_window`: the combinational byte rotator. It takes the flat buffer and `rd_ptr` and returns `o_window`.
- All state lives in `x86_prefetch_queue`.

## Test plan
- Reset with `RESET_EIP = 0`, memory always acks with data = address: window fills to `03020100 / 07060504`; `o_avail` reaches 8 after 2 acks; `o_rd` drops after 4 words.
- Flush to `0x00001003`: first ack of `0x1000` yields `o_avail = 1` with byte 0 = data[31:24]; `o_eip = 0x1003`.
- Full queue with `consume_bytes = 3` per cycle: `o_eip` advances by 3 each cycle and `o_rd` reasserts exactly when a word frees. Check no byte loss or duplication over 1000 bytes against a reference model.
- Flush, ack and consume in the same cycle: acked data discarded; `level = 0`; next `o_address = flush_eip & ~3`.
- Fetch across the address wrap from `0xFFFFFFFC`: next `o_address = 0`; window bytes are contiguous.
- `consume_bytes = 7` with `o_avail = 2`: advances by 2 only; `level = 0`; no underflow.
